// File: rtl/jtag_pkg.sv
// Shared TAP definitions: fixed state codes (also used by the instruction
// register), default instruction codes and the data-register select type.
package jtag_pkg;

  typedef enum logic [3:0] {
    TLR    = 4'd0,
    RTI    = 4'd1,
    SEL_DR = 4'd2,
    CAP_DR = 4'd3,
    SH_DR  = 4'd4,
    EX1_DR = 4'd5,
    PAU_DR = 4'd6,
    EX2_DR = 4'd7,
    UPD_DR = 4'd8,
    SEL_IR = 4'd9,
    CAP_IR = 4'd10,
    SH_IR  = 4'd11,
    EX1_IR = 4'd12,
    PAU_IR = 4'd13,
    EX2_IR = 4'd14,
    UPD_IR = 4'd15
  } tap_state_e;

  localparam logic [31:0] IDCODE_VAL_DEF   = 32'h1000_0001;
  localparam logic [3:0]  INSTR_IDCODE_DEF = 4'h1;
  localparam logic [3:0]  INSTR_USER_DEF   = 4'h8;
  localparam logic [3:0]  INSTR_BYPASS_DEF = 4'hF;

  typedef enum logic [1:0] {
    SEL_BYPASS = 2'd0,
    SEL_IDCODE = 2'd1,
    SEL_USER   = 2'd2
  } dr_sel_e;

endpackage

// File: rtl/jtag_tap_fsm.sv
// 16-state TAP state machine; the registered state is exported directly
// so the instruction register and debug logic see the same code.
module jtag_tap_fsm
  import jtag_pkg::*;
(
  input  logic       i_tck,
  input  logic       i_trst_n,
  input  logic       i_tms,
  output logic [3:0] o_tap_state
);

  tap_state_e r_state;

  always_ff @(posedge i_tck or negedge i_trst_n) begin
    if (!i_trst_n) begin
      r_state <= TLR;
    end else begin
      case (r_state)
        TLR:     r_state <= i_tms ? TLR    : RTI;
        RTI:     r_state <= i_tms ? SEL_DR : RTI;
        SEL_DR:  r_state <= i_tms ? SEL_IR : CAP_DR;
        CAP_DR:  r_state <= i_tms ? EX1_DR : SH_DR;
        SH_DR:   r_state <= i_tms ? EX1_DR : SH_DR;
        EX1_DR:  r_state <= i_tms ? UPD_DR : PAU_DR;
        PAU_DR:  r_state <= i_tms ? EX2_DR : PAU_DR;
        EX2_DR:  r_state <= i_tms ? UPD_DR : SH_DR;
        UPD_DR:  r_state <= i_tms ? SEL_DR : RTI;
        SEL_IR:  r_state <= i_tms ? TLR    : CAP_IR;
        CAP_IR:  r_state <= i_tms ? EX1_IR : SH_IR;
        SH_IR:   r_state <= i_tms ? EX1_IR : SH_IR;
        EX1_IR:  r_state <= i_tms ? UPD_IR : PAU_IR;
        PAU_IR:  r_state <= i_tms ? EX2_IR : PAU_IR;
        EX2_IR:  r_state <= i_tms ? UPD_IR : SH_IR;
        UPD_IR:  r_state <= i_tms ? SEL_DR : RTI;
        default: r_state <= TLR;
      endcase
    end
  end

  assign o_tap_state = r_state;

endmodule

// File: rtl/jtag_tap_controller.sv
// TAP controller top: state machine, IR decode, BYPASS/IDCODE registers,
// user-DR strobes and the falling-edge TDO mux.
module jtag_tap_controller
  import jtag_pkg::*;
#(
  parameter logic [31:0] IDCODE_VAL   = IDCODE_VAL_DEF,
  parameter logic [3:0]  INSTR_IDCODE = INSTR_IDCODE_DEF,
  parameter logic [3:0]  INSTR_USER   = INSTR_USER_DEF,
  parameter logic [3:0]  INSTR_BYPASS = INSTR_BYPASS_DEF
) (
  input  logic       TCK,
  input  logic       TRST_N,
  input  logic       TMS,
  input  logic       TDI,
  input  logic [3:0] IR,
  input  logic       IR_tdo,
  input  logic       user_tdo,
  output logic [3:0] tap_state,
  output logic       user_capture,
  output logic       user_shift,
  output logic       user_update,
  output logic       tlr,
  output logic       TDO,
  output logic       TDO_en
);

  logic        r_bypass;
  logic [31:0] r_idcode;
  dr_sel_e     w_sel;
  logic        w_dr_tdo;
  logic        w_capture_dr;
  logic        w_shift_dr;

  jtag_tap_fsm u_fsm (
    .i_tck       (TCK),
    .i_trst_n    (TRST_N),
    .i_tms       (TMS),
    .o_tap_state (tap_state)
  );

  // IR only changes in UPD_IR, so this decode is stable across DR scans.
  always_comb begin
    w_sel = SEL_BYPASS;
    if (IR == INSTR_IDCODE)      w_sel = SEL_IDCODE;
    else if (IR == INSTR_USER)   w_sel = SEL_USER;
    else if (IR == INSTR_BYPASS) w_sel = SEL_BYPASS;
  end

  assign w_capture_dr = (tap_state == CAP_DR);
  assign w_shift_dr   = (tap_state == SH_DR);

  assign tlr          = (tap_state == TLR);
  assign user_capture = w_capture_dr && (w_sel == SEL_USER);
  assign user_shift   = w_shift_dr   && (w_sel == SEL_USER);
  assign user_update  = (tap_state == UPD_DR) && (w_sel == SEL_USER);

  always_ff @(posedge TCK or negedge TRST_N) begin
    if (!TRST_N) begin
      r_bypass <= 1'b0;
      r_idcode <= IDCODE_VAL;
    end else if (w_capture_dr) begin
      if (w_sel == SEL_BYPASS) r_bypass <= 1'b0;
      if (w_sel == SEL_IDCODE) r_idcode <= IDCODE_VAL;
    end else if (w_shift_dr) begin
      if (w_sel == SEL_BYPASS) r_bypass <= TDI;
      if (w_sel == SEL_IDCODE) r_idcode <= {TDI, r_idcode[31:1]};
    end
  end

  always_comb begin
    case (w_sel)
      SEL_IDCODE: w_dr_tdo = r_idcode[0];
      SEL_USER:   w_dr_tdo = user_tdo;
      default:    w_dr_tdo = r_bypass;
    endcase
  end

  // Falling-edge launch gives the receiver half a cycle of setup before
  // the next rising TCK; TDO keeps its last bit outside the shift states.
  always_ff @(negedge TCK or negedge TRST_N) begin
    if (!TRST_N) begin
      TDO    <= 1'b0;
      TDO_en <= 1'b0;
    end else if (tap_state == SH_IR) begin
      TDO    <= IR_tdo;
      TDO_en <= 1'b1;
    end else if (w_shift_dr) begin
      TDO    <= w_dr_tdo;
      TDO_en <= 1'b1;
    end else begin
      TDO_en <= 1'b0;
    end
  end

endmodule

// File: tb/tb_jtag_tap_controller.sv
// Directed + randomized bench for jtag_tap_controller with a table-driven
// TAP model and a behavioural 4-bit instruction register.
module tb_jtag_tap_controller;

  localparam logic [31:0] EXP_IDCODE = 32'h1000_0001;
  localparam logic [3:0]  I_IDCODE   = 4'h1;
  localparam logic [3:0]  I_USER     = 4'h8;
  localparam logic [3:0]  I_BYPASS   = 4'hF;

  logic       TCK, TRST_N, TMS, TDI, IR_tdo, user_tdo;
  logic [3:0] IR;
  logic [3:0] tap_state;
  logic       user_capture, user_shift, user_update, tlr, TDO, TDO_en;

  logic [3:0] ir_sr;
  int         m_state;
  int         checks   = 0;
  int         failures = 0;

  int ns0 [16] = '{1, 1, 3, 4, 4, 6, 6, 4, 1, 10, 11, 11, 13, 13, 11, 1};
  int ns1 [16] = '{0, 2, 9, 5, 5, 8, 7, 8, 2, 0, 12, 12, 15, 14, 15, 2};

  assign IR_tdo = ir_sr[0];

  jtag_tap_controller dut (
    .TCK          (TCK),
    .TRST_N       (TRST_N),
    .TMS          (TMS),
    .TDI          (TDI),
    .IR           (IR),
    .IR_tdo       (IR_tdo),
    .user_tdo     (user_tdo),
    .tap_state    (tap_state),
    .user_capture (user_capture),
    .user_shift   (user_shift),
    .user_update  (user_update),
    .tlr          (tlr),
    .TDO          (TDO),
    .TDO_en       (TDO_en)
  );

  initial begin
    TCK = 1'b0;
    forever #10 TCK = ~TCK;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One TCK cycle: drive inputs, advance the models at the rising edge,
  // then compare every decoded output after the falling edge.
  task automatic tick(input logic tms, input logic tdi);
    TMS      = tms;
    TDI      = tdi;
    user_tdo = 1'($urandom_range(0, 1));
    @(posedge TCK);
    if (m_state == 10)      ir_sr = 4'b0001;
    else if (m_state == 11) ir_sr = {tdi, ir_sr[3:1]};
    else if (m_state == 15) IR = ir_sr;
    m_state = tms ? ns1[m_state] : ns0[m_state];
    @(negedge TCK);
    #1;
    check("state",    32'(tap_state),    32'(m_state));
    check("tdo_en",   32'(TDO_en),       32'(m_state == 4 || m_state == 11));
    check("tlr",      32'(tlr),          32'(m_state == 0));
    check("user_cap", 32'(user_capture), 32'(m_state == 3 && IR == I_USER));
    check("user_sh",  32'(user_shift),   32'(m_state == 4 && IR == I_USER));
    check("user_upd", 32'(user_update),  32'(m_state == 8 && IR == I_USER));
  endtask

  // From RTI: load v into the IR; returns the four bits seen on TDO.
  task automatic ir_scan(input logic [3:0] v, output logic [3:0] tdo);
    tick(1'b1, 1'b0);
    tick(1'b1, 1'b0);
    tick(1'b0, 1'b0);
    tick(1'b0, 1'b0);
    tdo[0] = TDO;
    for (int i = 1; i < 4; i++) begin
      tick(1'b0, v[i-1]);
      tdo[i] = TDO;
    end
    tick(1'b1, v[3]);
    tick(1'b1, 1'b0);
    tick(1'b0, 1'b0);
  endtask

  // From RTI: n-bit DR scan, optional pause before bit pause_at, optional
  // reset just after bit abort_at-1 has been seen (ends in TLR).
  task automatic dr_scan(input int n, input logic [31:0] tdi, input int pause_at,
                         input int abort_at, output logic [31:0] tdo,
                         output logic [31:0] ubits);
    tdo   = '0;
    ubits = '0;
    tick(1'b1, 1'b0);
    tick(1'b0, 1'b0);
    tick(1'b0, 1'b0);
    tdo[0]   = TDO;
    ubits[0] = user_tdo;
    for (int i = 1; i < n; i++) begin
      if (i == abort_at) begin
        TRST_N = 1'b0;
        #2;
        check("rst_state", 32'(tap_state), 32'd0);
        check("rst_en",    32'(TDO_en),    32'd0);
        check("rst_tdo",   32'(TDO),       32'd0);
        check("rst_tlr",   32'(tlr),       32'd1);
        m_state = 0;
        @(negedge TCK);
        #1;
        TRST_N = 1'b1;
        return;
      end
      if (i == pause_at) begin
        tick(1'b1, tdi[i-1]);
        repeat (5) tick(1'b0, 1'b0);
        tick(1'b1, 1'b0);
        tick(1'b0, 1'b0);
      end else begin
        tick(1'b0, tdi[i-1]);
      end
      tdo[i]   = TDO;
      ubits[i] = user_tdo;
    end
    tick(1'b1, tdi[n-1]);
    tick(1'b1, 1'b0);
    tick(1'b0, 1'b0);
  endtask

  function automatic logic [31:0] mask_n(input int n);
    return 32'((64'd1 << n) - 64'd1);
  endfunction

  initial begin
    logic [3:0]  ir_out;
    logic [31:0] tdo_v, ub, din;
    int          n;

    TRST_N = 1'b0; TMS = 1'b1; TDI = 1'b0; user_tdo = 1'b0;
    IR = I_IDCODE; ir_sr = 4'h0; m_state = 0;
    #25;
    check("reset_state", 32'(tap_state), 32'd0);
    check("reset_tlr",   32'(tlr),       32'd1);
    check("reset_tdo",   32'(TDO),       32'd0);
    check("reset_en",    32'(TDO_en),    32'd0);
    check("reset_user",  32'({user_capture, user_shift, user_update}), 32'd0);
    @(negedge TCK);
    #1;
    TRST_N = 1'b1;

    tick(1'b0, 1'b0);
    check("rti_after_0", 32'(tap_state), 32'd1);
    repeat (5) tick(1'b1, 1'b0);
    check("five_ones", 32'(tap_state), 32'd0);

    // IR scan of 4'b0001 from TLR; captured IR pattern comes out first.
    tick(1'b0, 1'b0);
    ir_scan(I_IDCODE, ir_out);
    check("ir_capture_out", 32'(ir_out), 32'h1);

    dr_scan(32, $urandom, -1, -1, tdo_v, ub);
    check("idcode_scan", tdo_v, EXP_IDCODE);

    ir_scan(I_BYPASS, ir_out);
    check("ir_capture_out2", 32'(ir_out), 32'h1);
    dr_scan(8, 32'hA5, -1, -1, tdo_v, ub);
    check("bypass_a5", tdo_v, 32'h4A);
    for (int k = 0; k < 5; k++) begin
      n   = $urandom_range(1, 32);
      din = $urandom;
      dr_scan(n, din, -1, -1, tdo_v, ub);
      check("bypass_rand", tdo_v & mask_n(n), (din << 1) & mask_n(n));
    end

    ir_scan(I_USER, ir_out);
    for (int k = 0; k < 3; k++) begin
      n = $urandom_range(2, 12);
      dr_scan(n, $urandom, -1, -1, tdo_v, ub);
      check("user_tdo", tdo_v & mask_n(n), ub & mask_n(n));
    end

    ir_scan(4'h3, ir_out);
    dr_scan(8, 32'h3C, -1, -1, tdo_v, ub);
    check("undef_ir_bypass", tdo_v, 32'h78);

    ir_scan(I_IDCODE, ir_out);
    dr_scan(32, $urandom, -1, 10, tdo_v, ub);
    check("abort_partial", tdo_v & mask_n(10), EXP_IDCODE & mask_n(10));
    tick(1'b0, 1'b0);
    dr_scan(32, $urandom, -1, -1, tdo_v, ub);
    check("idcode_rescan", tdo_v, EXP_IDCODE);
    dr_scan(32, $urandom, 12, -1, tdo_v, ub);
    check("idcode_pause", tdo_v, EXP_IDCODE);

    for (int k = 0; k < 4; k++) begin
      repeat (40) tick(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      repeat (5) tick(1'b1, 1'b0);
      check("recover_tlr", 32'(tap_state), 32'd0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
